// File: rtl/addsub_chunked.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_chunked
//  Description : Chunk-serial adder/subtractor. It adds CHUNK bits per clock
//                and registers the status flags. Operands are accepted over a
//                valid/ready handshake. The result is returned over a second
//                valid/ready handshake.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n           clock, asynchronous active-low reset
//    in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//    x, y, sub            operands; sub=1 selects z = x - y
//    out_valid/out_ready  result handshake (out_valid high only in DONE)
//    z                    result modulo 2^WIDTH
//    sign, zero, carry,   status flags for z (carry=1 on sub means no borrow,
//    parity, overflow     parity=1 for even number of ones)
// ============================================================================
module addsub_chunked #(
    parameter int WIDTH = 16,   // multiple of CHUNK, >= 2
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             sign,
    output logic             zero,
    output logic             carry,
    output logic             parity,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;      // operand A, shifted right one chunk per cycle
    logic [WIDTH-1:0] r_b;      // effective operand B (already inverted for sub)
    logic [WIDTH-1:0] r_res;    // result shift register, filled from the top
    logic             r_carry;
    logic [IW-1:0]    r_idx;

    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_full;

    // The current chunk always sits in the low CHUNK bits of r_a / r_b.
    assign w_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, r_carry};

    // Result register after this cycle's chunk is inserted at the top. On the
    // last chunk this is the complete result.
    assign w_full = (r_res >> CHUNK)
                  | (WIDTH'(w_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            z        <= '0;
            sign     <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            parity   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= x;
                        r_b     <= sub ? ~y : y;
                        // Subtraction is x + ~y + 1; the +1 enters as carry-in.
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_res   <= w_full;
                    r_carry <= w_sum[CHUNK];
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == IW'(N - 1)) begin
                        // The low chunk of r_a / r_b now holds the operand MSBs.
                        z        <= w_full;
                        sign     <= w_full[WIDTH-1];
                        zero     <= (w_full == '0);
                        carry    <= w_sum[CHUNK];
                        parity   <= ~^w_full;
                        overflow <= (r_a[CHUNK-1] == r_b[CHUNK-1])
                                  & (w_full[WIDTH-1] != r_a[CHUNK-1]);
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_chunked.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_chunked
//  Description : Self-checking bench for addsub_chunked. It uses a 16/4
//                instance for the directed cases and a 32/8 instance for the
//                random sweep.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_addsub_chunked;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        iv, ir, ov, ordy, sb;
    logic [15:0] x, y, z;
    logic        sign, zero, carry, par, ovf;

    // 32-bit instance
    logic        iv2, ir2, ov2, ordy2, sb2;
    logic [31:0] x2, y2, z2;
    logic        sign2, zero2, carry2, par2, ovf2;

    addsub_chunked #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
        .x(x), .y(y), .sub(sb), .out_valid(ov), .out_ready(ordy),
        .z(z), .sign(sign), .zero(zero), .carry(carry),
        .parity(par), .overflow(ovf)
    );

    addsub_chunked #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
        .x(x2), .y(y2), .sub(sb2), .out_valid(ov2), .out_ready(ordy2),
        .z(z2), .sign(sign2), .zero(zero2), .carry(carry2),
        .parity(par2), .overflow(ovf2)
    );

    wire [20:0] obs16 = {z, sign, zero, carry, par, ovf};
    wire [36:0] obs32 = {z2, sign2, zero2, carry2, par2, ovf2};

    int checks = 0;
    int errors = 0;

    logic [20:0] q16[$];
    logic [36:0] q32[$];

    // Reference: whole-word add of x and (sub ? ~y : y) with carry-in = sub
    function automatic logic [20:0] ref16(input logic [15:0] a, b, input logic s);
        logic [15:0] bb;
        logic [16:0] r;
        bb = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + 17'(s);
        return {r[15:0], r[15], (r[15:0] == 16'd0), r[16], ~^r[15:0],
                (a[15] == bb[15]) && (r[15] != a[15])};
    endfunction

    function automatic logic [36:0] ref32(input logic [31:0] a, b, input logic s);
        logic [31:0] bb;
        logic [32:0] r;
        bb = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + 33'(s);
        return {r[31:0], r[31], (r[31:0] == 32'd0), r[32], ~^r[31:0],
                (a[31] == bb[31]) && (r[31] != a[31])};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while dut16 is idle; returns at the negedge after accept.
    task automatic issue16(input logic [15:0] a, b, input logic s);
        x = a; y = b; sb = s; iv = 1'b1;
        q16.push_back(ref16(a, b, s));
        chk("in_ready_idle16", 64'(ir), 64'd1);
        @(negedge clk);
        iv = 1'b0;
        // Scramble operands while BUSY: they must have no effect.
        x = 16'($urandom); y = 16'($urandom); sb = 1'($urandom);
    endtask

    task automatic wait_out16(input string tag);
        int cnt;
        logic [20:0] e;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!ov && cnt < 20);
        chk({tag, "_latency"}, 64'(cnt), 64'd4);
        if (q16.size() > 0) begin
            e = q16.pop_front();
            chk(tag, 64'(obs16), 64'(e));
        end
    endtask

    task automatic release16();
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        chk("out_valid_drop16", 64'(ov), 64'd0);
        chk("in_ready_back16", 64'(ir), 64'd1);
    endtask

    task automatic op32(input logic [31:0] a, b, input logic s);
        int cnt;
        logic [36:0] e;
        x2 = a; y2 = b; sb2 = s; iv2 = 1'b1;
        q32.push_back(ref32(a, b, s));
        @(negedge clk);
        iv2 = 1'b0; x2 = $urandom; y2 = $urandom; sb2 = 1'($urandom);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!ov2 && cnt < 20);
        chk("lat32", 64'(cnt), 64'd4);
        e = q32.pop_front();
        chk("res32", 64'(obs32), 64'(e));
        ordy2 = 1'b1;
        @(negedge clk);
        ordy2 = 1'b0;
    endtask

    initial begin
        logic [20:0] snap;
        logic [31:0] corner [5];
        logic [31:0] a, b;
        logic        s;

        rst_n = 1'b0;
        iv = 0; ordy = 0; x = 0; y = 0; sb = 0;
        iv2 = 0; ordy2 = 0; x2 = 0; y2 = 0; sb2 = 0;
        repeat (2) @(negedge clk);
        chk("reset_out16", 64'(obs16), 64'd0);
        chk("reset_ov16", 64'(ov), 64'd0);
        chk("reset_ir16", 64'(ir), 64'd1);
        chk("reset_out32", 64'(obs32), 64'd0);
        rst_n = 1'b1;

        // Directed adds/subs
        issue16(16'h7FFF, 16'h0001, 1'b0); wait_out16("add_7fff_1");
        chk("add_7fff_1_z", 64'(z), 64'h8000);
        release16();
        issue16(16'hFFFF, 16'h0001, 1'b0); wait_out16("add_ffff_1");
        chk("add_ffff_1_zero", 64'(zero), 64'd1);
        release16();
        issue16(16'h0005, 16'h0007, 1'b1); wait_out16("sub_5_7");
        chk("sub_5_7_z", 64'(z), 64'hFFFE);
        release16();
        issue16(16'h8000, 16'h0001, 1'b1); wait_out16("sub_8000_1");
        release16();

        // Backpressure with a new pair waiting on in_valid
        issue16(16'h1234, 16'h1111, 1'b0); wait_out16("bp_first");
        x = 16'hA5A5; y = 16'h5A5A; sb = 1'b1; iv = 1'b1;
        q16.push_back(ref16(16'hA5A5, 16'h5A5A, 1'b1));
        snap = obs16;
        repeat (10) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(ir), 64'd0);
            chk("bp_out_valid", 64'(ov), 64'd1);
            chk("bp_stable", 64'(obs16), 64'(snap));
        end
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        chk("bp_in_ready_after", 64'(ir), 64'd1);
        @(negedge clk);
        iv = 1'b0;
        x = 16'($urandom); y = 16'($urandom); sb = 1'($urandom);
        wait_out16("bp_second");
        release16();

        // Asynchronous reset during the second BUSY cycle
        issue16(16'h0F0F, 16'h0101, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", 64'(obs16), 64'd0);
        chk("rst_mid_ov", 64'(ov), 64'd0);
        chk("rst_mid_ir", 64'(ir), 64'd1);
        q16.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue16(16'h1357, 16'h2468, 1'b1); wait_out16("after_rst");
        release16();

        // 32/8 sweep: corner pairs with both operations, then random
        corner[0] = 32'h0000_0000; corner[1] = 32'h8000_0000; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h0000_0001;
        for (int i = 0; i < 1000; i++) begin
            if (i < 50) begin
                a = corner[i % 5];
                b = corner[(i / 5) % 5];
                s = 1'(i / 25);
            end else begin
                a = $urandom; b = $urandom; s = 1'($urandom);
            end
            op32(a, b, s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
